// File: rtl/firc_phase_ctrl.sv
`timescale 1ns / 1ps
// -----------------------------------------------------------------------------
// firc_phase_ctrl
//
// Sequencer for the 29-tap folded complex FIR datapath (5 pre-adders and
// 5 complex multipliers, time-shared over 3 phases per sample).
//
// It pops a sample from the input FIFO, shifts the delay line and then issues
// three phases. For each phase it drives the lane-0 tap and coefficient bases.
// Issued phases are tracked through the pre-adder and multiplier pipeline with
// a tag shift register. At the pipe output the tags steer the output
// accumulator (load on phase 0, add on phases 1 and 2). PushOut is raised one
// cycle after the phase-2 tag leaves the pipe.
// Sample starts are held off for the cycle of a coefficient write and for the
// cycle after it.
//
// Optional build macro:
//   FIRC_OVERLAP_EN - a back-to-back sample pops the FIFO during PH2 and goes
//                     straight to PH0, so it skips LOAD. This gives 3 cycles
//                     per sample instead of 4.
//
// Ports:
//   Clk         in   clock
//   Reset       in   synchronous, active-high reset
//   FifoEmpty   in   input FIFO empty
//   PushCoef    in   coefficient write strobe
//   FifoRd      out  pop the FIFO head
//   ShiftEn     out  delay line shifts and captures the FIFO head this cycle
//   Phase[1:0]  out  issue phase 0..2, or 3 when not issuing
//   PhaseValid  out  lanes issue a valid phase this cycle
//   TapBaseA    out  lane-0 side-a tap index (lane k: a=TapBaseA+k,
//                    b=28-TapBaseA-k)
//   Lane4BZero  out  zero lane-4 operand b (centre tap counted once)
//   CoefBase    out  lane-0 coefficient address (lane k adds k)
//   AccLoad     out  accumulator loads the product sum
//   AccEn       out  accumulator adds the product sum
//   PushOut     out  filter output valid
//   Busy        out  sequencer active or phases still in flight
//   CoefHazard  out  sticky: coefficient write seen while a phase was issuing
// -----------------------------------------------------------------------------
module firc_phase_ctrl #(
    parameter int PIPE_LAT = 3,
    parameter int NPHASE   = 3
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       FifoEmpty,
    input  logic       PushCoef,
    output logic       FifoRd,
    output logic       ShiftEn,
    output logic [1:0] Phase,
    output logic       PhaseValid,
    output logic [4:0] TapBaseA,
    output logic       Lane4BZero,
    output logic [4:0] CoefBase,
    output logic       AccLoad,
    output logic       AccEn,
    output logic       PushOut,
    output logic       Busy,
    output logic       CoefHazard
);

    localparam logic [1:0] LAST_PHASE = 2'(NPHASE - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_PH0,
        ST_PH1,
        ST_PH2
    } state_t;

    typedef struct packed {
        logic       valid;
        logic [1:0] phase;
    } tag_t;

    state_t state, state_nxt;
    logic   coef_hold;
    logic   coef_hazard_q;
    logic   push_out_q;
    tag_t   tag_pipe [PIPE_LAT];
    tag_t   tag_in;
    tag_t   tag_out;
    logic   in_flight;
    logic   start;

    // A coefficient write blocks a new sample during the write cycle and the
    // cycle after it. A sample already in progress runs to completion.
    assign start = !FifoEmpty && !PushCoef && !coef_hold;

    // NOTE: every output of this process gets a default before the case
    // statement. This means no path can leave a value unassigned and infer
    // a latch.
    always_comb begin
        state_nxt  = state;
        FifoRd     = 1'b0;
        ShiftEn    = 1'b0;
        Phase      = 2'd3;
        PhaseValid = 1'b0;
        TapBaseA   = 5'd0;
        CoefBase   = 5'd0;
        Lane4BZero = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                FifoRd    = 1'b1;
                ShiftEn   = 1'b1;
                state_nxt = ST_PH0;
            end
            ST_PH0: begin
                PhaseValid = 1'b1;
                Phase      = 2'd0;
                state_nxt  = ST_PH1;
            end
            ST_PH1: begin
                PhaseValid = 1'b1;
                Phase      = 2'd1;
                TapBaseA   = 5'd5;
                CoefBase   = 5'd5;
                state_nxt  = ST_PH2;
            end
            ST_PH2: begin
                PhaseValid = 1'b1;
                Phase      = 2'd2;
                TapBaseA   = 5'd10;
                CoefBase   = 5'd10;
                // Lane 4 in PH2 reads a=14 and b=14. Zeroing b counts the
                // centre tap only once.
                Lane4BZero = 1'b1;
                if (start) begin
`ifdef FIRC_OVERLAP_EN
                    // The pre-adders sample the delay line on the same edge
                    // that shifts it, so PH2 can shift in the next sample.
                    FifoRd    = 1'b1;
                    ShiftEn   = 1'b1;
                    state_nxt = ST_PH0;
`else
                    state_nxt = ST_LOAD;
`endif
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign tag_in  = {PhaseValid, Phase};
    assign tag_out = tag_pipe[PIPE_LAT-1];

    // The pending PushOut is the accumulator-stage tag. It keeps Busy high
    // until the output pulse has been delivered.
    always_comb begin
        in_flight = push_out_q;
        for (int i = 0; i < PIPE_LAT; i++) begin
            in_flight = in_flight | tag_pipe[i].valid;
        end
    end

    // NOTE: state is updated with non-blocking assignments. Every register
    // then samples values from before the clock edge, whatever order the
    // statements are in.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state         <= ST_IDLE;
            coef_hold     <= 1'b0;
            coef_hazard_q <= 1'b0;
            push_out_q    <= 1'b0;
            // NOTE: the tag pipe is only a few flops and holds control
            // state. It must be cleared so that an abandoned sample can
            // never reach the accumulator or PushOut.
            for (int i = 0; i < PIPE_LAT; i++) begin
                tag_pipe[i] <= '0;
            end
        end else begin
            state      <= state_nxt;
            coef_hold  <= PushCoef;
            push_out_q <= tag_out.valid && (tag_out.phase == LAST_PHASE);
            if (PushCoef && PhaseValid) coef_hazard_q <= 1'b1;
            tag_pipe[0] <= tag_in;
            for (int i = 1; i < PIPE_LAT; i++) begin
                tag_pipe[i] <= tag_pipe[i-1];
            end
        end
    end

    assign AccLoad    = tag_out.valid && (tag_out.phase == 2'd0);
    assign AccEn      = tag_out.valid && (tag_out.phase != 2'd0);
    assign PushOut    = push_out_q;
    assign CoefHazard = coef_hazard_q;
    assign Busy       = (state != ST_IDLE) || in_flight;

endmodule

// File: doc/firc_phase_ctrl.md
Name: firc_phase_ctrl

Overview:
- Sequencer for the 29-tap folded complex FIR datapath: 5 pre-multiply adders and 5 complex multipliers, time-shared over 3 phases per sample.
- Pops samples from the input FIFO, advances the sample delay line and drives the phase/tap selects.
- Tracks in-flight phases through the adder and multiplier pipeline, controls the output accumulator and generates PushOut.
- Gates sample starts around coefficient writes.

Parameters:
- PIPE_LAT, 3, cycles from phase issue to product valid at the accumulator input (1 pre-adder + 2 multiplier stages).
- NPHASE, 3, phases per sample; fixed at 3 for 29 taps / 5 lanes.

Ports:
- Clk  in  1  clock.
- Reset  in  1  synchronous, active-high reset.
- FifoEmpty  in  1  input FIFO empty.
- PushCoef  in  1  coefficient write strobe (same signal as at the filter top).
- FifoRd  out  1  pop the FIFO head.
- ShiftEn  out  1  delay line shifts by one and captures the FIFO head at the end of this cycle.
- Phase  out  2  current issue phase: 0, 1 or 2; 3 when not issuing.
- PhaseValid  out  1  lanes issue a valid phase this cycle.
- TapBaseA  out  5  lane-0 "a" tap index. Lane k uses TapBaseA+k on side a and 28-TapBaseA-k on side b.
- Lane4BZero  out  1  force lane-4 operand b to zero (centre tap 14 counted once).
- CoefBase  out  5  coefficient bank address for lane 0; lanes add k.
- AccLoad  out  1  accumulator loads the product sum (first phase of a sample).
- AccEn  out  1  accumulator adds the product sum.
- PushOut  out  1  FI/FQ valid this cycle.
- Busy  out  1  state is not IDLE, or any in-flight tag is set.
- CoefHazard  out  1  sticky: PushCoef was seen while PhaseValid=1.

Behaviour:
- Reset (synchronous):
  - State returns to IDLE; in-flight tag pipe, CoefHold and CoefHazard clear.
  - All outputs are 0 the following cycle, except Phase=3.
  - Reset mid-sample abandons that sample. No PushOut for it, ever.
- States: IDLE, LOAD, PH0, PH1, PH2.
- Start condition: start = !FifoEmpty && !PushCoef && !CoefHold.
  - CoefHold is a 1-cycle register set by PushCoef, so a start is blocked during PushCoef and for 1 cycle after it.
- IDLE: if start, go to LOAD; else stay.
- LOAD: FifoRd=1, ShiftEn=1; then go to PH0.
  - FifoEmpty cannot change to empty between the start decision and LOAD, because the only reader is this block.
- PH0: PhaseValid=1, Phase=0, TapBaseA=0, CoefBase=0; go to PH1.
- PH1: Phase=1, TapBaseA=5, CoefBase=5; go to PH2.
- PH2: Phase=2, TapBaseA=10, CoefBase=10, Lane4BZero=1.
  - If start, go to LOAD; else go to IDLE.
- Throughput: 4 cycles per sample, back-to-back.
- PushCoef does not stop a sample in progress. A sample started before PushCoef completes all three phases.
- In-flight tag pipe: a PIPE_LAT-deep shift register of {valid, phase}, loaded every cycle from {PhaseValid, Phase}.
- At the pipe output, for a valid tag:
  - phase 0: AccLoad=1.
  - phase 1 or 2: AccEn=1.
  - AccLoad and AccEn are never both 1.
- PushOut is 1 exactly one cycle after the phase-2 tag exits the pipe (the accumulator register stage).
  - Latency from the PH2 issue cycle to PushOut is PIPE_LAT+1 = 4 cycles.
  - Exactly one PushOut per LOAD.
- Accumulator width and saturation belong to the datapath. This block only sequences it.
- Simultaneous PushCoef and PH2 with the FIFO non-empty: go to IDLE, not LOAD. The start resumes at the earliest 2 cycles after PushCoef falls.
- PushCoef while PhaseValid=1 sets CoefHazard. The write is not blocked; CoefHazard is a verification and debug flag. It clears only on Reset.

Optional Feature:
- Macro: FIRC_OVERLAP_EN.
- Defined:
  - LOAD is skipped for back-to-back samples. In PH2, if start, assert FifoRd=1 and ShiftEn=1 in the same cycle and go to PH0.
  - This is legal because the pre-adders sample the delay line at the same edge that shifts it.
  - Throughput becomes 3 cycles per sample. The IDLE to LOAD to PH0 path still applies after idle.
- Undefined: 4-cycle behaviour as above. FifoRd is never asserted in PH2.

Test Plan:
- Reset, then one sample written (FifoEmpty falls at cycle 0):
  - LOAD at cycle 1; PH0/PH1/PH2 at cycles 2/3/4.
  - AccLoad at 5, AccEn at 6 and 7, PushOut at 8.
  - Lane4BZero=1 only at cycle 4.
- FIFO held non-empty for 10 samples:
  - FifoRd every 4 cycles (every 3 with FIRC_OVERLAP_EN).
  - PushOut pulses 10 times, spaced identically.
  - Busy falls 1 cycle after the last PushOut.
- PushCoef pulsed in PH1 with the FIFO non-empty:
  - The current sample completes and PushOut is produced.
  - The next LOAD is delayed until 2 cycles after PushCoef falls.
  - CoefHazard=1 and stays 1.
- PushCoef held 5 cycles in IDLE with FIFO data present:
  - No FifoRd while held and 1 cycle after.
  - CoefHazard stays 0.
- Reset asserted in PH1:
  - Next cycle all outputs are 0 and Phase=3.
  - No AccEn or PushOut appears in the following 8 cycles.
- TapBaseA/CoefBase check over 3 samples: sequence 0, 5, 10 repeats. Lane-4 b index equals 14 in PH2 and is zeroed.
